// File: rtl/ccd_acq_ctrl.sv
// Linear-CCD acquisition sequencer: arms the timing generator, drops the first and flush lines,
// then read-modify-write accumulates cfg_avg lines into an external RAM. Optional macro: ACQ_CONT_EN.
module ccd_acq_ctrl #(
   parameter int N_PIX = 2048,
   parameter int ADC_W = 12,
   parameter int AVG_W = 8,
   parameter int ACC_W = 20
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic [AVG_W-1:0]         cfg_avg,
   input  logic [AVG_W-1:0]         cfg_skip,
   input  logic                     cfg_cont,
   input  logic                     frame_ack,
   input  logic                     tg_done,
   input  logic                     tg_sp,
   input  logic [ADC_W-1:0]         adc_data,
   output logic                     tg_rst_n,
   output logic [$clog2(N_PIX)-1:0] acc_addr,
   output logic [ACC_W-1:0]         acc_wdata,
   output logic                     acc_we,
   input  logic [ACC_W-1:0]         acc_rdata,
   output logic                     busy,
   output logic                     frame_ready,
   output logic [AVG_W-1:0]         line_cnt
);
   localparam int IDX_W = $clog2(N_PIX);

   typedef enum logic [2:0] {S_IDLE, S_ARM, S_FLUSH, S_ACCUM, S_READY} state_t;

   state_t             r_state, w_state_nx;
   logic               r_done_d, r_sp_d;
   logic [AVG_W-1:0]   r_avg, r_skip, r_line_cnt;
   logic [IDX_W:0]     r_idx;
   logic               r_line_pend;
   logic               r_vld_p0, r_vld_p1, r_we;
   logic [IDX_W-1:0]   r_addr;
   logic [ADC_W-1:0]   r_sample;
   logic [ACC_W-1:0]   r_wdata;
`ifdef ACQ_CONT_EN
   logic               r_cont;
`else
   logic               w_unused_cont;
   assign w_unused_cont = cfg_cont;
`endif

   logic               w_line_edge, w_samp_edge, w_rmw_busy, w_start_rmw;
   logic               w_line_req, w_line_go, w_latch;
   logic [AVG_W-1:0]   w_line_cnt_nx, w_avg_in;
   logic [ACC_W-1:0]   w_sum;

   assign w_line_edge   = tg_done & ~r_done_d;
   assign w_samp_edge   = tg_sp & ~r_sp_d;
   assign w_rmw_busy    = r_vld_p0 | r_vld_p1 | r_we;
   // Sample pulses arriving while an RMW is in flight or a line end is pending are dropped.
   assign w_start_rmw   = (r_state == S_ACCUM) & w_samp_edge & ~w_rmw_busy & ~r_line_pend
                          & (r_idx < (IDX_W+1)'(N_PIX));
   assign w_line_req    = (r_state == S_ACCUM) & (w_line_edge | r_line_pend);
   assign w_line_go     = w_line_req & ~w_rmw_busy & ~w_start_rmw;
   assign w_line_cnt_nx = r_line_cnt + AVG_W'(1);
   assign w_avg_in      = (cfg_avg == '0) ? AVG_W'(1) : cfg_avg;
   assign w_sum         = acc_rdata + ACC_W'(r_sample);

   always_comb begin
      w_state_nx = r_state;
      w_latch    = 1'b0;
      case (r_state)
         S_IDLE: if (start) begin
            w_state_nx = S_ARM;
            w_latch    = 1'b1;
         end
         S_ARM: if (w_line_edge) w_state_nx = (r_skip != '0) ? S_FLUSH : S_ACCUM;
         S_FLUSH: if (w_line_edge && r_skip == AVG_W'(1)) w_state_nx = S_ACCUM;
         S_ACCUM: if (w_line_go && w_line_cnt_nx == r_avg) w_state_nx = S_READY;
         S_READY: if (frame_ack) begin
`ifdef ACQ_CONT_EN
            if (r_cont) begin
               w_state_nx = S_ARM;
               w_latch    = 1'b1;
            end else begin
               w_state_nx = S_IDLE;
            end
`else
            w_state_nx = S_IDLE;
`endif
         end
         default: w_state_nx = S_IDLE;
      endcase
      if (abort) begin
         w_state_nx = S_IDLE;
         w_latch    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done_d    <= 1'b0;
         r_sp_d      <= 1'b0;
         r_avg       <= '0;
         r_skip      <= '0;
         r_line_cnt  <= '0;
         r_idx       <= '0;
         r_line_pend <= 1'b0;
         r_vld_p0    <= 1'b0;
         r_vld_p1    <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_sample    <= '0;
         r_wdata     <= '0;
`ifdef ACQ_CONT_EN
         r_cont      <= 1'b0;
`endif
      end else begin
         r_done_d <= tg_done;
         r_sp_d   <= tg_sp;
         if (abort) begin
            r_line_cnt  <= '0;
            r_idx       <= '0;
            r_line_pend <= 1'b0;
            r_vld_p0    <= 1'b0;
            r_vld_p1    <= 1'b0;
            r_we        <= 1'b0;
         end else begin
            // RMW: p0 drives the address, p1 sees read data, then one write cycle.
            r_vld_p0 <= w_start_rmw;
            r_vld_p1 <= r_vld_p0;
            r_we     <= r_vld_p1;
            if (w_start_rmw) begin
               r_addr   <= r_idx[IDX_W-1:0];
               r_sample <= adc_data;
            end
            if (r_vld_p1) begin
               r_wdata <= (r_line_cnt == '0) ? ACC_W'(r_sample) : w_sum;
               r_idx   <= r_idx + (IDX_W+1)'(1);
            end
            if (w_latch) begin
               r_avg       <= w_avg_in;
               r_skip      <= cfg_skip;
               r_line_cnt  <= '0;
               r_idx       <= '0;
               r_line_pend <= 1'b0;
`ifdef ACQ_CONT_EN
               r_cont      <= cfg_cont;
`endif
            end else if (r_state == S_FLUSH && w_line_edge) begin
               r_skip <= r_skip - AVG_W'(1);
            end
            // A line end seen mid-RMW is held until the write has landed.
            if (w_line_go) begin
               r_idx       <= '0;
               r_line_cnt  <= w_line_cnt_nx;
               r_line_pend <= 1'b0;
            end else if (w_line_req) begin
               r_line_pend <= 1'b1;
            end
         end
      end
   end

   assign tg_rst_n    = (r_state == S_ARM) | (r_state == S_FLUSH) | (r_state == S_ACCUM);
   assign busy        = (r_state != S_IDLE);
   assign frame_ready = (r_state == S_READY);
   assign line_cnt    = r_line_cnt;
   assign acc_addr    = r_addr;
   assign acc_wdata   = r_wdata;
   assign acc_we      = r_we;

endmodule

// File: tb/tb_ccd_acq_ctrl.sv
// Self-checking bench for ccd_acq_ctrl: table-driven acquisitions, hand-written corner sequences,
// and randomized acquisitions checked against a line-sum model of the expected RAM contents.
module tb_ccd_acq_ctrl;
   localparam int NP = 8;

`ifdef ACQ_CONT_EN
   localparam bit CONT_EN = 1'b1;
`else
   localparam bit CONT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, start, abort, cfg_cont, frame_ack, tg_done, tg_sp;
   logic [7:0]  cfg_avg, cfg_skip;
   logic [11:0] adc_data;
   logic        tg_rst_n, acc_we, busy, frame_ready;
   logic [2:0]  acc_addr;
   logic [19:0] acc_wdata, acc_rdata;
   logic [7:0]  line_cnt;

   logic [19:0] mem [NP];
   logic [11:0] data [10][12];
   int          wr_cnt = 0;
   int          n_chk = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   ccd_acq_ctrl #(.N_PIX(NP), .ADC_W(12), .AVG_W(8), .ACC_W(20)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .cfg_avg(cfg_avg), .cfg_skip(cfg_skip), .cfg_cont(cfg_cont), .frame_ack(frame_ack),
      .tg_done(tg_done), .tg_sp(tg_sp), .adc_data(adc_data), .tg_rst_n(tg_rst_n),
      .acc_addr(acc_addr), .acc_wdata(acc_wdata), .acc_we(acc_we), .acc_rdata(acc_rdata),
      .busy(busy), .frame_ready(frame_ready), .line_cnt(line_cnt)
   );

   // Accumulator RAM with one-cycle read latency.
   always @(posedge clk) begin
      acc_rdata <= mem[acc_addr];
      if (acc_we) mem[acc_addr] <= acc_wdata;
   end

   always @(posedge clk) if (acc_we === 1'b1) wr_cnt <= wr_cnt + 1;

   typedef struct {
      int avg; int skip; int nsp; int mode; int tail; int cont; int exp_lc;
   } vec_t;
   vec_t tbl [6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic gen_data(input int mode);
      for (int l = 0; l < 10; l++)
         for (int k = 0; k < 12; k++)
            case (mode)
               0:       data[l][k] = 12'(k + 1);
               1:       data[l][k] = 12'hFFF;
               default: data[l][k] = 12'($urandom_range(0, 4095));
            endcase
   endtask

   // tail: 0 = line end after a gap, 1 = line end with the last sample, 2 = line end mid-RMW.
   task automatic drive_line(input int l, input int nsp, input int tail);
      for (int k = 0; k < nsp; k++) begin
         adc_data = data[l][k];
         tg_sp    = 1'b1;
         if (k == nsp - 1 && tail == 1) tg_done = 1'b1;
         tick();
         tg_sp = 1'b0;
         if (k == nsp - 1 && tail == 2) tg_done = 1'b1;
         repeat (5) tick();
      end
      tg_done = 1'b1;
      tick();
      tick();
      tg_done = 1'b0;
      repeat (3) tick();
   endtask

   task automatic run_acq(input int avg, input int skip, input int nsp, input int mode,
                          input int tail, input int cont, input int exp_lc);
      int eff, nlines, nw, w0, cyc;
      logic [19:0] expv;
      eff    = (avg == 0) ? 1 : avg;
      nlines = 1 + skip + eff;
      nw     = (nsp < NP) ? nsp : NP;
      gen_data(mode);
      cfg_avg  = 8'(avg);
      cfg_skip = 8'(skip);
      cfg_cont = cont[0];
      w0       = wr_cnt;
      start    = 1'b1;
      tick();
      start = 1'b0;
      chk("arm_busy", 32'(busy), 32'd1);
      chk("arm_tg_rst_n", 32'(tg_rst_n), 32'd1);
      for (int l = 0; l < nlines; l++) drive_line(l, nsp, tail);
      cyc = 0;
      while (frame_ready !== 1'b1 && cyc < 100) begin
         tick();
         cyc++;
      end
      chk("frame_ready", 32'(frame_ready), 32'd1);
      chk("ready_tg_rst_n", 32'(tg_rst_n), 32'd0);
      chk("ready_busy", 32'(busy), 32'd1);
      chk("line_cnt", 32'(line_cnt), 32'(exp_lc));
      chk("write_count", 32'(wr_cnt - w0), 32'(eff * nw));
      for (int i = 0; i < nw; i++) begin
         expv = '0;
         for (int l = 1 + skip; l < nlines; l++) expv = expv + 20'(data[l][i]);
         chk($sformatf("ram[%0d]", i), 32'(mem[i]), 32'(expv));
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("start_in_ready", 32'(frame_ready), 32'd1);
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
      if (cont != 0 && CONT_EN) begin
         chk("cont_busy", 32'(busy), 32'd1);
         chk("cont_tg_rst_n", 32'(tg_rst_n), 32'd1);
         chk("cont_frame_ready", 32'(frame_ready), 32'd0);
         abort = 1'b1;
         tick();
         abort = 1'b0;
         chk("cont_abort_busy", 32'(busy), 32'd0);
      end else begin
         chk("ack_busy", 32'(busy), 32'd0);
         chk("ack_frame_ready", 32'(frame_ready), 32'd0);
         chk("ack_tg_rst_n", 32'(tg_rst_n), 32'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_cont = 1'b0; frame_ack = 1'b0;
      tg_done = 1'b0; tg_sp = 1'b0; cfg_avg = '0; cfg_skip = '0; adc_data = '0;
      tick();
      tick();
      chk("rst_tg_rst_n", 32'(tg_rst_n), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_acc_we", 32'(acc_we), 32'd0);
      chk("rst_acc_addr", 32'(acc_addr), 32'd0);
      chk("rst_acc_wdata", 32'(acc_wdata), 32'd0);
      chk("rst_frame_ready", 32'(frame_ready), 32'd0);
      chk("rst_line_cnt", 32'(line_cnt), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_busy", 32'(busy), 32'd0);

      tbl[0] = '{1, 0, 8, 0, 0, 0, 1};
      tbl[1] = '{4, 2, 8, 1, 0, 0, 4};
      tbl[2] = '{2, 1, 10, 0, 0, 0, 2};
      tbl[3] = '{0, 0, 8, 2, 0, 0, 1};
      tbl[4] = '{3, 0, 6, 2, 1, 0, 3};
      tbl[5] = '{2, 1, 8, 2, 2, 1, 2};
      for (int t = 0; t < 6; t++)
         run_acq(tbl[t].avg, tbl[t].skip, tbl[t].nsp, tbl[t].mode, tbl[t].tail,
                 tbl[t].cont, tbl[t].exp_lc);

      // Abort while flushing.
      gen_data(0);
      cfg_avg = 8'd2; cfg_skip = 8'd3; cfg_cont = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      drive_line(0, 4, 0);
      drive_line(1, 4, 0);
      chk("flush_busy", 32'(busy), 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_tg_rst_n", 32'(tg_rst_n), 32'd0);
      chk("abort_line_cnt", 32'(line_cnt), 32'd0);
      chk("abort_frame_ready", 32'(frame_ready), 32'd0);

      // Asynchronous reset during the write cycle of an RMW.
      cfg_avg = 8'd2; cfg_skip = 8'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      drive_line(0, 2, 0);
      adc_data = 12'h123;
      tg_sp    = 1'b1;
      tick();
      tg_sp = 1'b0;
      tick();
      tick();
      chk("rmw_we_before_rst", 32'(acc_we), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_tg_rst_n", 32'(tg_rst_n), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_acc_we", 32'(acc_we), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_tg_rst_n", 32'(tg_rst_n), 32'd0);

      for (int r = 0; r < 6; r++) begin
         int ra;
         ra = int'($urandom_range(0, 5));
         run_acq(ra, int'($urandom_range(0, 3)), int'($urandom_range(1, 11)), 2,
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), (ra == 0) ? 1 : ra);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
